instr_fetch_queue: RTL and testbench

Parametrised instruction fetch unit with a prefetch queue, replacing the single load-on-demand instruction register of the multi-cycle core. It streams sequential words from the instruction port of the synchronous RAM into a DEPTH-entry first-word-fall-through queue and tags each word with its PC. The controller consumes words with a valid/ready handshake and redirects fetch on branches, which flushes the queue and any in-flight read.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fwft_fifo.sv | 71 +++++++
 rtl/instr_fetch_queue.sv | 131 +++++++++++++
 tb/tb_instr_fetch_queue.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths and entry type for the instruction fetch queue
//
// Purpose: default address/data widths of the instruction RAM and the
// {pc, data} entry layout held by the prefetch queue.
// Ports: none (package).
package fetch_pkg;

    localparam int FETCH_ADDR_W_DEF = 11;
    localparam int FETCH_DATA_W_DEF = 32;

    // One queue entry at the default widths; pc occupies the upper bits.
    typedef struct packed {
        logic [FETCH_ADDR_W_DEF-1:0] pc;
        logic [FETCH_DATA_W_DEF-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/fwft_fifo.sv
// rtl/fwft_fifo.sv - first-word-fall-through queue with synchronous flush
//
// Purpose: DEPTH-entry FIFO whose head entry is always visible on head_o.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   push_i           write push_data_i at the tail (caller never overflows)
//   push_data_i      entry to write
//   pop_i            drop the head entry (ignored when empty)
//   flush_i          empty the queue; overrides push and pop
//   head_o           head entry
//   count_o          occupancy, 0..DEPTH
module fwft_fifo #(
    parameter int  WIDTH = 43,
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !flush_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - sequential instruction prefetch with branch redirect
//
// Purpose: streams words from the synchronous instruction RAM into a
// DEPTH-entry FWFT queue tagged with their word address; a redirect flushes
// the queue and any in-flight read and restarts fetch at redirect_pc.
// Optional feature macro: FETCH_STATS_EN adds fetch_cnt/flush_cnt outputs.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   ram_rd_en          read strobe to the RAM
//   ram_addr1          read word address
//   ram_data1          read data, valid the cycle after the strobe
//   redirect_valid     redirect request, redirect_pc = new fetch address
//   instr_valid        head entry present
//   instr, instr_pc    head instruction and its word address
//   instr_ready        consumer accepts the head this cycle
//   count              queue occupancy
//   fetch_cnt          words pushed (FETCH_STATS_EN only)
//   flush_cnt          redirects accepted (FETCH_STATS_EN only)
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int  ADDR_W   = FETCH_ADDR_W_DEF,
    parameter int  DATA_W   = FETCH_DATA_W_DEF,
    parameter int  DEPTH    = 4,
    parameter int  RESET_PC = 0,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr1,
    input  logic [DATA_W-1:0] ram_data1,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    output logic [CNT_W-1:0]  count
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);

    logic [ADDR_W-1:0]        fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]        rd_pc_q, rd_pc_d;
    logic                     inflight_q, inflight_d;
    logic                     kill_q, kill_d;
    logic                     issue;
    logic                     push;
    logic                     pop;
    logic [CNT_W:0]           credit;
    logic [ADDR_W+DATA_W-1:0] head;

    // Slots already spoken for: queued words plus the one read still in
    // flight. A pop in the same cycle frees nothing for this decision.
    assign credit = {1'b0, count} + (CNT_W + 1)'(inflight_q);
    assign issue  = !rst && !redirect_valid && (credit < (CNT_W + 1)'(DEPTH));

    assign ram_rd_en = issue;
    assign ram_addr1 = fetch_pc_q;

    // A returning word is dropped if it was killed by last cycle's redirect
    // or if a redirect is flushing the queue right now.
    assign push = inflight_q && !kill_q && !redirect_valid;
    assign pop  = instr_valid && instr_ready && !redirect_valid;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid)  fetch_pc_d = redirect_pc;
        else if (issue)      fetch_pc_d = fetch_pc_q + ADDR_W'(1);
        rd_pc_d    = issue ? fetch_pc_q : rd_pc_q;
        inflight_d = issue;
        kill_d     = redirect_valid && inflight_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_ADDR;
            rd_pc_q    <= '0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_pc_q    <= rd_pc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
        end
    end

    fwft_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i ({rd_pc_q, ram_data1}),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .head_o      (head),
        .count_o     (count)
    );

    assign instr_valid = (count != '0);
    assign instr_pc    = head[ADDR_W+DATA_W-1:DATA_W];
    assign instr       = head[DATA_W-1:0];

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (push)           fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (redirect_valid) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - randomized self-checking bench for instr_fetch_queue
module tb_instr_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = FETCH_ADDR_W_DEF;
    localparam int DATA_W = FETCH_DATA_W_DEF;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_addr1;
    logic [DATA_W-1:0] ram_data1;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;
    logic [CNT_W-1:0]  count;
`ifdef FETCH_STATS_EN
    logic [31:0]       fetch_cnt;
    logic [31:0]       flush_cnt;
`endif

    always #5 clk = ~clk;

    instr_fetch_queue #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .RESET_PC (0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ram_rd_en      (ram_rd_en),
        .ram_addr1      (ram_addr1),
        .ram_data1      (ram_data1),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .count          (count)
`ifdef FETCH_STATS_EN
        ,
        .fetch_cnt      (fetch_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    // Synchronous-read instruction RAM; junk on the data bus when not read.
    logic [DATA_W-1:0] mem [1 << ADDR_W];
    always @(posedge clk) begin
        if (ram_rd_en) ram_data1 <= mem[ram_addr1];
        else           ram_data1 <= $urandom;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the words the consumer should see, as a queue.
    fetch_entry_t      mq[$];
    bit                m_pend;
    logic [ADDR_W-1:0] m_pend_pc;
    logic [ADDR_W-1:0] m_pc;
    int                m_fetch;
    int                m_flush;

    task automatic model_reset();
        mq.delete();
        m_pend  = 1'b0;
        m_pc    = '0;
        m_fetch = 0;
        m_flush = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".rd_en"}, 64'(ram_rd_en), 64'(0));
        check({tag, ".addr"},  64'(ram_addr1), 64'(0));
        check({tag, ".valid"}, 64'(instr_valid), 64'(0));
        check({tag, ".instr"}, 64'(instr), 64'(0));
        check({tag, ".pc"},    64'(instr_pc), 64'(0));
        check({tag, ".count"}, 64'(count), 64'(0));
`ifdef FETCH_STATS_EN
        check({tag, ".fetch_cnt"}, 64'(fetch_cnt), 64'(0));
        check({tag, ".flush_cnt"}, 64'(flush_cnt), 64'(0));
`endif
    endtask

    // One clock cycle: drive inputs at the falling edge, check, advance model.
    task automatic cycle(input bit rv, input logic [ADDR_W-1:0] rpc, input bit rdy);
        bit e_issue;
        @(negedge clk);
        redirect_valid = rv;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        #1;
        e_issue = !rv && ((mq.size() + int'(m_pend)) < DEPTH);
        check("rd_en", 64'(ram_rd_en), 64'(e_issue));
        check("addr",  64'(ram_addr1), 64'(m_pc));
        check("valid", 64'(instr_valid), 64'(mq.size() != 0));
        check("count", 64'(count), 64'(mq.size()));
        if (mq.size() != 0) begin
            check("instr_pc", 64'(instr_pc), 64'(mq[0].pc));
            check("instr",    64'(instr),    64'(mq[0].data));
        end
`ifdef FETCH_STATS_EN
        check("fetch_cnt", 64'(fetch_cnt), 64'(m_fetch));
        check("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
        if (rv) begin
            mq.delete();
            m_pend = 1'b0;
            m_pc   = rpc;
            m_flush++;
        end else begin
            if (rdy && mq.size() != 0) void'(mq.pop_front());
            if (m_pend) begin
                mq.push_back(fetch_entry_t'{pc: m_pend_pc, data: mem[m_pend_pc]});
                m_fetch++;
            end
            m_pend = e_issue;
            if (e_issue) begin
                m_pend_pc = m_pc;
                m_pc      = m_pc + 1'b1;
            end
        end
    endtask

    // Asynchronous reset between edges, held for a couple of cycles, released
    // mid-cycle so the following cycle is the first with rst low.
    task automatic apply_reset(input string tag);
        @(posedge clk);
        #3;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        #1;
        check_reset_outputs(tag);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs({tag, ".held"});
        #1;
        rst = 1'b0;
    endtask

    task automatic random_run(input int n);
        bit                rv;
        logic [ADDR_W-1:0] rpc;
        bit                rdy;
        for (int i = 0; i < n; i++) begin
            rv  = ($urandom % 10) == 0;
            rpc = (($urandom % 4) == 0) ? (ADDR_W'(11'h7FC) + ADDR_W'($urandom % 4))
                                        : ADDR_W'($urandom);
            rdy = ($urandom % 4) != 0;
            cycle(rv, rpc, rdy);
        end
    endtask

    int max_cnt;

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'(i) + 32'h100;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b1;
        model_reset();

        // Power-on reset, then a streaming run with the consumer always ready.
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        #1;
        rst = 1'b0;
        repeat (30) cycle(1'b0, '0, 1'b1);

        // Consumer stalls: queue fills to DEPTH and fetch stops.
        max_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, '0, 1'b0);
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
        check("stall_saturation", 64'(max_cnt), 64'(DEPTH));
        repeat (20) cycle(1'b0, '0, 1'b1);

        // Redirect while a read is in flight, with ready high the same cycle.
        cycle(1'b1, 11'h040, 1'b1);
        repeat (15) cycle(1'b0, '0, 1'b1);

        // Redirect near the top of the address space to exercise the wrap.
        cycle(1'b1, 11'h7FE, 1'b0);
        repeat (12) cycle(1'b0, '0, 1'b1);

        // Back-to-back redirects: the last one wins.
        cycle(1'b1, 11'h010, 1'b1);
        cycle(1'b1, 11'h020, 1'b0);
        repeat (10) cycle(1'b0, '0, 1'b1);

        // Fresh memory contents, then random traffic.
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = $urandom;
        random_run(400);

        // Reset in the middle of a busy stream, then resume.
        repeat (5) cycle(1'b0, '0, 1'b1);
        apply_reset("mid_rst");
        repeat (20) cycle(1'b0, '0, 1'b1);
        random_run(200);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
